// File: rtl/vga_timing_gen.sv
// 640x480@60 style VGA timing generator: a divide-by-two pixel tick from CLK_50, an h/v raster
// counter, and the sync/blank outputs delayed to line up with a downstream pixel pipeline.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int PIPE_LAT  = 2
) (
  input  logic       CLK_50,
  input  logic       RESET,
  output logic       PIX_EN,
  output logic       VGA_CLK,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       VISIBLE,
  output logic       LINE_START,
  output logic       FRAME_START,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic       VGA_SYNC_N
);

  localparam logic [9:0] H_TOTAL    = 10'(H_VISIBLE + H_FP + H_SYNC + H_BP);
  localparam logic [9:0] V_TOTAL    = 10'(V_VISIBLE + V_FP + V_SYNC + V_BP);
  localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START   = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_END     = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START   = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_END     = 10'(V_VISIBLE + V_FP + V_SYNC);

  logic       phase_q, phase_d;
  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;
  logic       hs_raw, vs_raw, vis_raw;

  always_comb begin
    phase_d = ~phase_q;
    h_d     = h_q;
    v_d     = v_q;
    if (phase_q) begin
      if (h_q == H_TOTAL - 10'd1) begin
        h_d = '0;
        v_d = (v_q == V_TOTAL - 10'd1) ? 10'd0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
    end
  end

  always_ff @(posedge CLK_50) begin
    if (!RESET) begin
      phase_q <= 1'b0;
      h_q     <= '0;
      v_q     <= '0;
    end else begin
      phase_q <= phase_d;
      h_q     <= h_d;
      v_q     <= v_d;
    end
  end

  assign hs_raw  = !((h_q >= HS_START) && (h_q < HS_END));
  assign vs_raw  = !((v_q >= VS_START) && (v_q < VS_END));
  assign vis_raw = (h_q < H_VIS) && (v_q < V_VIS);

  assign PIX_EN      = phase_q;
  assign VGA_CLK     = phase_q;
  assign DrawX       = h_q;
  assign DrawY       = v_q;
  // Raster position (0,0) is visible, so the flag is masked while reset is held.
  assign VISIBLE     = RESET && vis_raw;
  assign LINE_START  = phase_q && (h_q == 10'd0);
  assign FRAME_START = phase_q && (h_q == 10'd0) && (v_q == 10'd0);
  assign VGA_SYNC_N  = 1'b0;

  generate
    if (PIPE_LAT == 0) begin : g_nopipe
      assign VGA_HS      = hs_raw;
      assign VGA_VS      = vs_raw;
      assign VGA_BLANK_N = VISIBLE;
    end else begin : g_pipe
      // Each stage holds {hsync, vsync, visible} and moves one slot per pixel tick.
      logic [2:0] pipe_q [PIPE_LAT];

      always_ff @(posedge CLK_50) begin
        if (!RESET) begin
          for (int i = 0; i < PIPE_LAT; i++) pipe_q[i] <= 3'b110;
        end else if (phase_q) begin
          pipe_q[0] <= {hs_raw, vs_raw, vis_raw};
          for (int i = 1; i < PIPE_LAT; i++) pipe_q[i] <= pipe_q[i-1];
        end
      end

      assign {VGA_HS, VGA_VS, VGA_BLANK_N} = pipe_q[PIPE_LAT-1];
    end
  endgenerate

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
Parameters (name, default, meaning):
REQ-001 H_VISIBLE, 640, visible pixels per line.
REQ-002 H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync widths in pixel ticks; H_TOTAL = 800.
REQ-003 V_VISIBLE, 480, visible lines per frame.
REQ-004 V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync widths in lines; V_TOTAL = 525.
REQ-005 PIPE_LAT, 2, downstream pixel-path latency in pixel ticks, legal range 0..7.

Ports (name, direction, width, meaning):
REQ-006 CLK_50  in  1  sole clock, 50 MHz.
REQ-007 RESET  in  1  synchronous, active-low reset.
REQ-008 PIX_EN  out  1  pixel tick, high every second CLK_50 cycle.
REQ-009 VGA_CLK  out  1  25 MHz pixel clock to the DAC, registered.
REQ-010 DrawX  out  10  current horizontal counter, 0..H_TOTAL-1.
REQ-011 DrawY  out  10  current vertical counter, 0..V_TOTAL-1.
REQ-012 VISIBLE  out  1  undelayed active-area flag for (DrawX, DrawY).
REQ-013 LINE_START  out  1  one-cycle pulse at each line start.
REQ-014 FRAME_START  out  1  one-cycle pulse at each frame start.
REQ-015 VGA_HS, VGA_VS  out  1 each  active-low syncs, delayed by PIPE_LAT ticks.
REQ-016 VGA_BLANK_N  out  1  active-low blank, delayed by PIPE_LAT ticks.
REQ-017 VGA_SYNC_N  out  1  constant 0.

Function
REQ-018 A 1-bit phase register SHALL toggle every CLK_50 cycle; PIX_EN SHALL be high when phase = 1.
REQ-019 VGA_CLK SHALL equal the registered phase value, so its rising edge coincides with the PIX_EN cycle.
REQ-020 The h counter (DrawX) SHALL advance only in cycles where PIX_EN = 1 and SHALL wrap from H_TOTAL-1 to 0.
REQ-021 The v counter (DrawY) SHALL advance only on an h wrap and SHALL wrap from V_TOTAL-1 to 0 when h wraps simultaneously.
REQ-022 DrawX and DrawY SHALL be registered counter values with no combinational path to the outputs; they are held for two CLK_50 cycles per tick.
REQ-023 VISIBLE SHALL be 1 iff DrawX < H_VISIBLE and DrawY < V_VISIBLE.
REQ-024 Raw hsync SHALL be low iff H_VISIBLE+H_FP <= DrawX < H_VISIBLE+H_FP+H_SYNC, i.e. 656..751.
REQ-025 Raw vsync SHALL be low iff V_VISIBLE+V_FP <= DrawY < V_VISIBLE+V_FP+V_SYNC, i.e. 490..491.
REQ-026 Raw {hsync, vsync, VISIBLE} SHALL pass through a PIPE_LAT-stage shift register that advances only on PIX_EN; stage outputs drive VGA_HS, VGA_VS, VGA_BLANK_N.
REQ-027 With PIPE_LAT = 0, VGA_HS, VGA_VS and VGA_BLANK_N SHALL equal the raw values registered in the same cycle as the counters.
REQ-028 LINE_START SHALL be high for exactly the one CLK_50 cycle in which PIX_EN = 1 and DrawX = 0.
REQ-029 FRAME_START SHALL be high for exactly the one CLK_50 cycle in which PIX_EN = 1, DrawX = 0 and DrawY = 0; LINE_START is also high in that cycle.
REQ-030 Counter widths SHALL be 10 bits; no counter SHALL ever hold a value >= its TOTAL.

Reset
REQ-031 While RESET = 0 at a CLK_50 edge, the following SHALL load: phase = 0, DrawX = 0, DrawY = 0, all delay stages = inactive (hsync 1, vsync 1, visible 0).
REQ-032 Output values during reset SHALL be: PIX_EN = 0, VGA_CLK = 0, VISIBLE = 0, LINE_START = 0, FRAME_START = 0, VGA_HS = 1, VGA_VS = 1, VGA_BLANK_N = 0.
REQ-033 Reset asserted mid-frame SHALL take effect at the next edge regardless of PIX_EN.
REQ-034 After release, the first PIX_EN SHALL occur in the second cycle, and FRAME_START SHALL pulse in that cycle with DrawX = DrawY = 0.

Verification
REQ-035 Reset release -> PIX_EN pattern 0,1,0,1...; FRAME_START and LINE_START pulse on cycle 2; VGA_BLANK_N stays 0 for PIPE_LAT ticks, then rises.
REQ-036 Run one line -> exactly 800 PIX_EN per LINE_START; VGA_HS low for 96 ticks, starting PIPE_LAT ticks after DrawX = 656.
REQ-037 Run one frame -> 420000 PIX_EN between FRAME_START pulses; VGA_VS low exactly for lines 490-491, delayed by PIPE_LAT ticks; DrawY never exceeds 524.
REQ-038 Corner DrawX = 799, DrawY = 524 -> the next tick gives (0, 0) with FRAME_START = 1; DrawX = 799, DrawY = 479 -> the next tick gives (0, 480) with VISIBLE = 0.
REQ-039 Assert RESET at DrawX = 300, DrawY = 200 for 3 cycles -> the outputs match REQ-032 on the next edge, and counting resumes from (0, 0).
REQ-040 PIPE_LAT = 0 build -> VGA_BLANK_N equals VISIBLE in every cycle.
